sparse_decoder_mc: RTL and testbench
====================================

Name: sparse_decoder_mc

Overview:
Multi-channel successor to the single-stream sparse decoder.
- Accepts NUM_CH independent (skip, value) run-length streams from SRAM.
- Reconstructs absolute indices per channel, resetting at vector boundaries.
- Merges the channels round-robin onto one ready/valid output tagged with channel id, for the comparison block.
- Adds credit-based flow control, index-overflow detection and per-vector restart.

Parameters:
- NUM_CH, 4, number of input channels (>=1)
- SKIP_W, 8, skip field width
- VALUE_W, 16, value field width
- INDEX_W, 16, reconstructed index width (>= SKIP_W)
- IN_FIFO_DEPTH, 8, per-channel input FIFO depth (power of 2)
- OUT_DEPTH, 4, output buffer entries; must be >=3 for 1 element/cycle

Ports:
- mac_clk  in  1  clock
- mac_rst  in  1  reset, asynchronous, active-low
- sram_valid_i  in  NUM_CH  per-channel input valid
- sram_ready_o  out  NUM_CH  per-channel input ready
- sram_last_i  in  NUM_CH  element is last of its vector
- sram_data_i  in  NUM_CH*(SKIP_W+VALUE_W)  packed {skip,value} per channel
- decoder_valid_o  out  1  output valid
- decoder_ready_i  in  1  output ready
- decoder_data_o  out  INDEX_W+VALUE_W  {index,value}
- decoder_ch_o  out  $clog2(NUM_CH) (min 1)  source channel
- decoder_last_o  out  1  last element of that channel's vector
- overflow_o  out  NUM_CH  sticky per-channel index overflow

Behaviour:
- Reset (async, mac_rst=0) clears all state:
  - sram_ready_o=0, decoder_valid_o=0, decoder_data_o=0, decoder_ch_o=0, decoder_last_o=0, overflow_o=0.
  - credits=OUT_DEPTH, rr pointer=NUM_CH-1, first[c]=1.
  - Reset mid-operation discards all buffered data; no partial output follows release.
- Input side:
  - sram_ready_o[c] = ~in_fifo_full[c] (registered state only).
  - Write on valid&ready; {last,skip,value} is stored per entry.
  - FIFO is fifo_sync with 1-cycle registered read latency.
- Issue stage (cycle N):
  - Eligible set = channels with non-empty FIFO; arbitration happens only when credits!=0.
  - Round-robin: search starts at pointer+1; the granted channel becomes the new pointer.
  - Grant asserts rden for that channel only; credits decrement.
- Decode stage (cycle N+1), on returned entry for channel c:
  - sum = first[c] ? skip : acc[c]+skip+1, computed in INDEX_W+1 bits.
  - If sum[INDEX_W]=1: overflow_o[c]<=1 (sticky until reset); entry dropped; acc unchanged; credit returned.
  - Else acc[c]<=sum[INDEX_W-1:0], first[c]<=0, and {sum,value,c,last} is pushed to the output buffer.
  - If last=1 (dropped or not): first[c]<=1 for the next element.
- Output buffer:
  - OUT_DEPTH-entry in-order FIFO; head drives decoder_* outputs; decoder_valid_o = non-empty.
  - Data stays stable while valid&~ready.
- Credits:
  - credits_next = credits - issue + handshake + drop.
  - Simultaneous issue and return leaves credits unchanged.
  - Credits never exceed OUT_DEPTH, so the buffer never overflows.
- Latency: input handshake to decoder_valid_o >= 3 cycles (FIFO write, issue, decode). Sustained 1 element/cycle across channels when OUT_DEPTH>=3 and decoder_ready_i=1.
- Ordering: elements of one channel leave in input order; inter-channel order follows arbitration.
- Index width: skip=2^SKIP_W-1 is legal; wrap is never silent — it is always flagged by overflow.

Optional Feature:
- Macro SPARSE_DEC_ZERO_FILTER_EN.
- Defined: entries with value==0 and last==0 update acc/first normally but are not pushed; their credit is returned as a drop. Zero-valued entries with last==1 are still emitted, so vector boundaries stay visible.
- Undefined: every non-overflowing entry is emitted regardless of value.

Decomposition:
- sparse_mac_pkg holds:
  - default width constants (SKIP_W, VALUE_W, INDEX_W, DECODER_FIFO_DEPTH);
  - typedefs sram_data_t {skip,value} and decoder_data_t {index,value} sized from those defaults;
  - a decoder_out_t {data,ch,last}.
- The module uses parameter-sized local packed structs.
- Natural sub-module: rr_arbiter (NUM_CH requests, enable, grant one-hot, pointer update).
- Existing fifo_sync is reused for the input and output buffers.

Test Plan:
1. Single channel 0, entries skip=3,0,5 (values 10,20,30), ready=1 -> indices 3,4,10, ch=0, 1 element/cycle after the first.
2. Channels 0..3 all loaded with 4 entries, ready=1 -> strict grant order 0,1,2,3,0,... with no idle cycles; per-channel indices correct.
3. Channel 1 sends skip=2 last=1, then skip=1 -> second index=1 (restart), decoder_last_o=1 on the first.
4. INDEX_W=8: acc=250 then skip=10 -> overflow_o[c]=1 sticky, entry not emitted; next skip=0 gives index 251.
5. decoder_ready_i=0 for 20 cycles -> at most OUT_DEPTH outputs buffered, head data stable, input FIFOs fill and sram_ready_o drops; release -> no loss or duplication.
6. Reset asserted mid-stream with full buffers -> all outputs 0 immediately; after release, the first element decodes with first=1.

Source files
------------

// File: rtl/sparse_mac_pkg.sv
// sparse_mac_pkg: default widths, shared stream typedefs and small helpers
// for the sparse decoder family.
package sparse_mac_pkg;

    localparam int SKIP_W             = 8;
    localparam int VALUE_W            = 16;
    localparam int INDEX_W            = 16;
    localparam int DECODER_FIFO_DEPTH = 8;
    localparam int CH_W               = 2;

    typedef struct packed {
        logic [SKIP_W-1:0]  skip;
        logic [VALUE_W-1:0] value;
    } sram_data_t;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [VALUE_W-1:0] value;
    } decoder_data_t;

    typedef struct packed {
        decoder_data_t   data;
        logic [CH_W-1:0] ch;
        logic            last;
    } decoder_out_t;

    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO, any depth. FWFT=0 gives a 1-cycle registered
// read; FWFT=1 presents the head combinationally.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter bit FWFT  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]    cnt_q;
    logic             wr, rd;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = cnt_q == NW'(DEPTH);
    assign empty_o   = cnt_q == '0;
    assign wr        = wr_en_i & ~full_o;
    assign rd        = rd_en_i & ~empty_o;
    assign rd_data_o = FWFT ? mem_q[rd_ptr_q] : rd_q;

    // Memory is reset so a FWFT head reads as zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            rd_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) mem_q[wr_ptr_q] <= wr_data_i;
            if (wr) wr_ptr_q <= inc(wr_ptr_q);
            if (rd) rd_q <= mem_q[rd_ptr_q];
            if (rd) rd_ptr_q <= inc(rd_ptr_q);
            cnt_q <= cnt_q + NW'(wr) - NW'(rd);
        end
    end

endmodule

// File: rtl/sparse_decoder_mc_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the search starts just after the
// previous winner, which becomes the new pointer.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);
    logic [PW-1:0] ptr_q, ptr_d, j;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = ptr_q;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= N; i++) begin
            j = PW'((int'(ptr_q) + i) % N);
            if (!found && en_i && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        ptr_d = found ? idx_o : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= PW'(N - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sparse_decoder_mc.sv
// sparse_decoder_mc: merges NUM_CH run-length (skip,value) streams into one
// indexed, channel-tagged stream. Zero-value filtering: SPARSE_DEC_ZERO_FILTER_EN.
module sparse_decoder_mc #(
    parameter  int NUM_CH        = 4,
    parameter  int SKIP_W        = sparse_mac_pkg::SKIP_W,
    parameter  int VALUE_W       = sparse_mac_pkg::VALUE_W,
    parameter  int INDEX_W       = sparse_mac_pkg::INDEX_W,
    parameter  int IN_FIFO_DEPTH = sparse_mac_pkg::DECODER_FIFO_DEPTH,
    parameter  int OUT_DEPTH     = 4,
    localparam int CW            = sparse_mac_pkg::clog2_min1(NUM_CH)
) (
    input  logic                          mac_clk,
    input  logic                          mac_rst,
    input  logic [NUM_CH-1:0]             sram_valid_i,
    output logic [NUM_CH-1:0]             sram_ready_o,
    input  logic [NUM_CH-1:0]             sram_last_i,
    input  logic [NUM_CH*(SKIP_W+VALUE_W)-1:0] sram_data_i,
    output logic                          decoder_valid_o,
    input  logic                          decoder_ready_i,
    output logic [INDEX_W+VALUE_W-1:0]    decoder_data_o,
    output logic [CW-1:0]                 decoder_ch_o,
    output logic                          decoder_last_o,
    output logic [NUM_CH-1:0]             overflow_o
);
    import sparse_mac_pkg::*;

    localparam int DW = SKIP_W + VALUE_W;
    localparam int KW = $clog2(OUT_DEPTH + 1);
`ifdef SPARSE_DEC_ZERO_FILTER_EN
    localparam bit ZERO_FILTER = 1'b1;
`else
    localparam bit ZERO_FILTER = 1'b0;
`endif

    typedef struct packed {
        logic               last;
        logic [SKIP_W-1:0]  skip;
        logic [VALUE_W-1:0] value;
    } in_ent_t;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [VALUE_W-1:0] value;
        logic [CW-1:0]      ch;
        logic               last;
    } out_ent_t;

    in_ent_t            in_q [NUM_CH];
    in_ent_t            ent;
    out_ent_t           out_w, head;
    logic [NUM_CH-1:0]  in_full, in_empty, rden;
    logic [CW-1:0]      gnt_idx, dec_ch_q;
    logic               run_q, dec_vld_q, issue, hs, zero, push, drop, out_full, out_empty;
    logic [KW-1:0]      credits_q, credits_d;
    logic [INDEX_W-1:0] acc_q [NUM_CH];
    logic [INDEX_W-1:0] acc_d [NUM_CH];
    logic [NUM_CH-1:0]  first_q, first_d, ovf_q, ovf_d;
    logic [INDEX_W:0]   sum;

    // run_q keeps ready low while in reset and for the first cycle after.
    assign sram_ready_o = run_q ? ~in_full : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_in
        fifo_sync #(.WIDTH(DW + 1), .DEPTH(IN_FIFO_DEPTH), .FWFT(1'b0)) u_in_fifo (
            .clk_i     (mac_clk),
            .rst_ni    (mac_rst),
            .wr_en_i   (sram_valid_i[c] & sram_ready_o[c]),
            .wr_data_i ({sram_last_i[c], sram_data_i[c*DW +: DW]}),
            .rd_en_i   (rden[c]),
            .rd_data_o (in_q[c]),
            .full_o    (in_full[c]),
            .empty_o   (in_empty[c])
        );
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk_i  (mac_clk),
        .rst_ni (mac_rst),
        .en_i   (credits_q != '0),
        .req_i  (~in_empty),
        .gnt_o  (rden),
        .idx_o  (gnt_idx)
    );

    assign issue = |rden;
    assign ent   = in_q[dec_ch_q];
    assign sum   = first_q[dec_ch_q] ? (INDEX_W+1)'(ent.skip)
                 : {1'b0, acc_q[dec_ch_q]} + (INDEX_W+1)'(ent.skip) + (INDEX_W+1)'(1);
    assign zero  = ZERO_FILTER && ent.value == '0 && !ent.last;
    assign push  = dec_vld_q & ~sum[INDEX_W] & ~zero;
    assign drop  = dec_vld_q & ~push;
    assign out_w = '{index: sum[INDEX_W-1:0], value: ent.value, ch: dec_ch_q, last: ent.last};

    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        ovf_d   = ovf_q;
        if (dec_vld_q) begin
            if (sum[INDEX_W]) ovf_d[dec_ch_q] = 1'b1;
            else begin
                acc_d[dec_ch_q]   = sum[INDEX_W-1:0];
                first_d[dec_ch_q] = 1'b0;
            end
            if (ent.last) first_d[dec_ch_q] = 1'b1;
        end
    end

    // Credits track free output slots including entries still in flight.
    assign hs        = decoder_valid_o & decoder_ready_i;
    assign credits_d = credits_q - KW'(issue) + KW'(hs) + KW'(drop);

    fifo_sync #(.WIDTH($bits(out_ent_t)), .DEPTH(OUT_DEPTH), .FWFT(1'b1)) u_out_fifo (
        .clk_i     (mac_clk),
        .rst_ni    (mac_rst),
        .wr_en_i   (push & ~out_full),
        .wr_data_i (out_w),
        .rd_en_i   (hs),
        .rd_data_o (head),
        .full_o    (out_full),
        .empty_o   (out_empty)
    );

    assign decoder_valid_o = ~out_empty;
    assign decoder_data_o  = {head.index, head.value};
    assign decoder_ch_o    = head.ch;
    assign decoder_last_o  = head.last;
    assign overflow_o      = ovf_q;

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            run_q     <= 1'b0;
            dec_vld_q <= 1'b0;
            dec_ch_q  <= '0;
            credits_q <= KW'(OUT_DEPTH);
            acc_q     <= '{default: '0};
            first_q   <= '1;
            ovf_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            dec_vld_q <= issue;
            dec_ch_q  <= gnt_idx;
            credits_q <= credits_d;
            acc_q     <= acc_d;
            first_q   <= first_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sparse_decoder_mc.sv
// tb_sparse_decoder_mc: scoreboard bench, directed scenarios plus randomized
// traffic against an integer reference model of the index reconstruction.
module tb_sparse_decoder_mc;
    localparam int NCH  = 4;
    localparam int SW   = 8;
    localparam int VW   = 16;
    localparam int IW   = 8;
    localparam int OD   = 4;
    localparam int CW   = 2;
    localparam int IMAX = (1 << IW) - 1;
`ifdef SPARSE_DEC_ZERO_FILTER_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct { int skip; int value; bit last; } elem_t;
    typedef struct { int index; int value; bit last; } exp_t;

    logic                    mac_clk = 1'b0;
    logic                    mac_rst = 1'b0;
    logic [NCH-1:0]          sram_valid_i = '0;
    logic [NCH-1:0]          sram_ready_o;
    logic [NCH-1:0]          sram_last_i = '0;
    logic [NCH*(SW+VW)-1:0]  sram_data_i = '0;
    logic                    decoder_valid_o;
    logic                    decoder_ready_i = 1'b0;
    logic [IW+VW-1:0]        decoder_data_o;
    logic [CW-1:0]           decoder_ch_o;
    logic                    decoder_last_o;
    logic [NCH-1:0]          overflow_o;

    sparse_decoder_mc #(.NUM_CH(NCH), .SKIP_W(SW), .VALUE_W(VW), .INDEX_W(IW),
                        .IN_FIFO_DEPTH(8), .OUT_DEPTH(OD)) dut (
        .mac_clk         (mac_clk),
        .mac_rst         (mac_rst),
        .sram_valid_i    (sram_valid_i),
        .sram_ready_o    (sram_ready_o),
        .sram_last_i     (sram_last_i),
        .sram_data_i     (sram_data_i),
        .decoder_valid_o (decoder_valid_o),
        .decoder_ready_i (decoder_ready_i),
        .decoder_data_o  (decoder_data_o),
        .decoder_ch_o    (decoder_ch_o),
        .decoder_last_o  (decoder_last_o),
        .overflow_o      (overflow_o)
    );

    always #5 mac_clk = ~mac_clk;

    int cyc = 0;
    always @(posedge mac_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    elem_t pend [NCH][$];
    exp_t  expq [NCH][$];
    int    m_acc [NCH];
    bit    m_first [NCH];
    bit [NCH-1:0] m_ovf;
    bit    gaps = 0, rdy_rand = 0, log_en = 0;
    int    log_ch[$], log_cyc[$], log_idx[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0;
            m_first[c] = 1;
            pend[c].delete();
            expq[c].delete();
        end
        m_ovf = '0;
    endtask

    // Reference: absolute index is the running sum of (skip+1) per vector,
    // with the first element contributing skip alone.
    task automatic model(int c, elem_t e);
        int s;
        s = m_first[c] ? e.skip : m_acc[c] + e.skip + 1;
        if (s > IMAX) m_ovf[c] = 1'b1;
        else begin
            m_acc[c] = s;
            m_first[c] = 0;
            if (!(ZF && e.value == 0 && !e.last)) expq[c].push_back('{s, e.value, e.last});
        end
        if (e.last) m_first[c] = 1;
    endtask

    task automatic send(int c, int sk, int v, bit l);
        pend[c].push_back('{sk, v, l});
    endtask

    function automatic bit busy();
        for (int c = 0; c < NCH; c++) if (pend[c].size() != 0 || expq[c].size() != 0) return 1;
        return decoder_valid_o;
    endfunction

    task automatic drain(string name);
        int n = 0;
        while (busy() && n < 4000) begin
            @(posedge mac_clk);
            n++;
        end
        n_cmp++;
        if (busy()) begin
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
        repeat (5) @(posedge mac_clk);
        #1;
    endtask

    task automatic log_clear();
        log_ch.delete();
        log_cyc.delete();
        log_idx.delete();
    endtask

    // Input driver: presents queued elements, feeds accepted ones to the model.
    initial begin
        logic [NCH-1:0] am;
        forever begin
            @(negedge mac_clk);
            am = sram_valid_i & sram_ready_o;
            @(posedge mac_clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (am[c] && pend[c].size() != 0) model(c, pend[c].pop_front());
                if (am[c] || !sram_valid_i[c]) begin
                    if (pend[c].size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                        sram_valid_i[c] = 1'b1;
                        sram_data_i[c*(SW+VW) +: SW+VW] = {SW'(pend[c][0].skip), VW'(pend[c][0].value)};
                        sram_last_i[c] = pend[c][0].last;
                    end else sram_valid_i[c] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge mac_clk);
        #1;
        if (rdy_rand) decoder_ready_i = $urandom_range(0, 3) != 0;
    end

    // Monitor: pops the channel's expected queue on every output handshake
    // and checks the head holds steady while stalled.
    initial begin
        exp_t e;
        int ch;
        logic [IW+VW+CW:0] saved;
        bit held = 0;
        forever begin
            @(negedge mac_clk);
            if (mac_rst && decoder_valid_o) begin
                if (decoder_ready_i) begin
                    ch = int'(decoder_ch_o);
                    if (expq[ch].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: ch=%0d index=%0d, required none", ch, decoder_data_o[VW +: IW]);
                    end else begin
                        e = expq[ch].pop_front();
                        chk("out_index", decoder_data_o[VW +: IW], e.index);
                        chk("out_value", decoder_data_o[VW-1:0], e.value);
                        chk("out_last", decoder_last_o, e.last);
                    end
                    if (log_en) begin
                        log_ch.push_back(ch);
                        log_cyc.push_back(cyc);
                        log_idx.push_back(int'(decoder_data_o[VW +: IW]));
                    end
                    held = 0;
                end else begin
                    if (held) chk("stall_stable", {decoder_data_o, decoder_ch_o, decoder_last_o}, saved);
                    saved = {decoder_data_o, decoder_ch_o, decoder_last_o};
                    held = 1;
                end
            end else held = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge mac_clk);
        #1;
        chk("rst_valid", decoder_valid_o, 0);
        chk("rst_data", decoder_data_o, 0);
        chk("rst_ch", decoder_ch_o, 0);
        chk("rst_last", decoder_last_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_sram_ready", sram_ready_o, 0);
        @(negedge mac_clk);
        mac_rst = 1'b1;
        repeat (2) @(posedge mac_clk);
        #1;
        chk("ready_after_rst", sram_ready_o, 4'hf);

        // All channels loaded: strict 0,1,2,3 rotation with no idle cycles.
        decoder_ready_i = 1'b1;
        log_clear();
        log_en = 1;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < NCH; c++) send(c, k + 1, c * 100 + k, k == 3);
        drain("rr");
        log_en = 0;
        chk("rr_count", log_ch.size(), 16);
        for (int k = 0; k < log_ch.size(); k++) begin
            chk("rr_order", log_ch[k], k % NCH);
            chk("rr_no_idle", log_cyc[k] - log_cyc[0], k);
        end

        // Single channel: indices 3,4,10 back to back.
        log_clear();
        log_en = 1;
        send(0, 3, 10, 0);
        send(0, 0, 20, 0);
        send(0, 5, 30, 1);
        drain("single");
        log_en = 0;
        chk("single_count", log_idx.size(), 3);
        if (log_idx.size() == 3) begin
            chk("single_idx0", log_idx[0], 3);
            chk("single_idx1", log_idx[1], 4);
            chk("single_idx2", log_idx[2], 10);
            chk("single_rate", log_cyc[2] - log_cyc[0], 2);
        end

        // Vector restart after last.
        log_clear();
        log_en = 1;
        send(1, 2, 5, 1);
        send(1, 1, 6, 1);
        drain("restart");
        log_en = 0;
        chk("restart_count", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
            chk("restart_idx0", log_idx[0], 2);
            chk("restart_idx1", log_idx[1], 1);
        end

        // Overflow: 250 then skip 10 wraps and is dropped; skip 0 gives 251.
        log_clear();
        log_en = 1;
        send(2, 250, 1, 0);
        send(2, 10, 2, 0);
        send(2, 0, 3, 1);
        drain("ovf");
        log_en = 0;
        chk("ovf_count", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
            chk("ovf_idx0", log_idx[0], 250);
            chk("ovf_idx1", log_idx[1], 251);
        end
        chk("ovf_flag", overflow_o, 4'b0100);
        repeat (3) @(posedge mac_clk);
        #1;
        chk("ovf_sticky", overflow_o[2], 1);

        // Output stall: buffers fill, inputs back-pressure, nothing lost.
        decoder_ready_i = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 12; k++) send(c, $urandom_range(0, 6), $urandom_range(1, 999), k == 11);
        repeat (20) @(posedge mac_clk);
        #1;
        chk("stall_valid", decoder_valid_o, 1);
        chk("stall_backpressure", sram_ready_o, 0);
        decoder_ready_i = 1'b1;
        drain("stall");

        // Randomized traffic with input gaps and random output ready.
        gaps = 1;
        rdy_rand = 1;
        for (int k = 0; k < 400; k++)
            send($urandom_range(0, NCH - 1),
                 $urandom_range(0, 9) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 20),
                 $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 65535),
                 $urandom_range(0, 5) == 0);
        drain("random");
        rdy_rand = 0;
        gaps = 0;
        decoder_ready_i = 1'b1;
        chk("random_ovf", overflow_o, m_ovf);

        // Reset with full buffers, then a clean restart.
        decoder_ready_i = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 10; k++) send(c, $urandom_range(0, 30), $urandom_range(1, 999), 0);
        repeat (15) @(posedge mac_clk);
        chk("prerst_valid", decoder_valid_o, 1);
        @(posedge mac_clk);
        #2;
        mac_rst = 1'b0;
        model_reset();
        sram_valid_i = '0;
        #1;
        chk("midrst_valid", decoder_valid_o, 0);
        chk("midrst_data", decoder_data_o, 0);
        chk("midrst_ch", decoder_ch_o, 0);
        chk("midrst_last", decoder_last_o, 0);
        chk("midrst_ovf", overflow_o, 0);
        chk("midrst_sram_ready", sram_ready_o, 0);
        repeat (3) @(posedge mac_clk);
        @(negedge mac_clk);
        mac_rst = 1'b1;
        repeat (4) @(posedge mac_clk);
        #1;
        chk("postrst_no_output", decoder_valid_o, 0);
        decoder_ready_i = 1'b1;
        log_clear();
        log_en = 1;
        send(3, 7, 99, 1);
        drain("postrst");
        log_en = 0;
        chk("postrst_count", log_idx.size(), 1);
        if (log_idx.size() == 1) chk("postrst_idx", log_idx[0], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
